ascon_perm_ctrl: RTL and testbench

- Sequencing controller for the six-round Ascon permutation chain (p_block_chain).
- Accepts a 320-bit state plus a permutation request (p^a = 12 rounds, p^b = PB_ROUNDS rounds) over a valid/ready handshake.
- Holds the state in a register, drives the chain's loop_num/const_sel/enable/compact_fast each iteration, and feeds the selected tap (x_out_6 or x_out_2) back.
- Returns the permuted state over a second valid/ready handshake.

---
 rtl/ascon_perm_pkg.sv | 26 ++
 rtl/ascon_perm_plan.sv | 47 ++++
 rtl/ascon_perm_ctrl.sv | 140 ++++++++++++++
 tb/tb_ascon_perm_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_perm_pkg.sv
// Shared definitions for the Ascon permutation sequencer.
//   STATE_W      : width of the Ascon state (five 64-bit words)
//   perm_state_t : controller FSM states
//   EN_FULL/EN_TWO : chain stage-enable patterns for the 6-round and 2-round taps
//   N_*          : iteration counts per mode (fast = 6 rounds/iter, compact = 2 rounds/iter)
package ascon_perm_pkg;

  localparam int STATE_W = 320;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } perm_state_t;

  localparam logic [5:0] EN_FULL = 6'b111111;
  localparam logic [5:0] EN_TWO  = 6'b110000;

  localparam logic [2:0] N_FAST_PA  = 3'd2;
  localparam logic [2:0] N_FAST_PB6 = 3'd1;
  localparam logic [2:0] N_FAST_PB8 = 3'd2;
  localparam logic [2:0] N_CMP_PA   = 3'd6;
  localparam logic [2:0] N_CMP_PB6  = 3'd3;
  localparam logic [2:0] N_CMP_PB8  = 3'd4;

endpackage

// File: rtl/ascon_perm_plan.sv
// Combinational iteration plan for one permutation request.
//   pb      : 0 = p^a (12 rounds), 1 = p^b (PB_ROUNDS rounds)
//   fast    : 1 = six rounds per iteration, 0 = two rounds per iteration
//   counter : current iteration index
//   n       : number of iterations for this mode
//   is_last : counter is the final iteration
//   tap_sel : 1 = take the six-round tap, 0 = take the two-round tap
module ascon_perm_plan
  import ascon_perm_pkg::*;
#(
  parameter int PB_ROUNDS = 6
) (
  input  logic       pb,
  input  logic       fast,
  input  logic [2:0] counter,
  output logic [2:0] n,
  output logic       is_last,
  output logic       tap_sel
);

  always_comb begin
    n       = N_CMP_PA;
    tap_sel = 1'b0;
    if (fast) begin
      tap_sel = 1'b1;
      if (!pb) begin
        n = N_FAST_PA;
      end else if (PB_ROUNDS == 8) begin
        // 8 rounds in fast mode: one full 6-round pass, then a 2-round pass.
        n       = N_FAST_PB8;
        tap_sel = (counter == 3'd0);
      end else begin
        n = N_FAST_PB6;
      end
    end else begin
      if (!pb) begin
        n = N_CMP_PA;
      end else if (PB_ROUNDS == 8) begin
        n = N_CMP_PB8;
      end else begin
        n = N_CMP_PB6;
      end
    end
    is_last = (counter == (n - 3'd1));
  end

endmodule

// File: rtl/ascon_perm_ctrl.sv
// Sequencing controller for the six-round Ascon permutation chain.
// Accepts a state and a p^a/p^b request, iterates the external chain, feeding
// the selected tap back into the state register, and returns the result.
//   clk, rst_n            : clock, synchronous active-low reset
//   start_valid/ready     : request handshake (ready only in IDLE)
//   start_state/pb/fast   : request payload, sampled on accept
//   chain_*               : drive / taps of the external p_block_chain
//   res_valid/ready/state : result handshake, state is the state register
//   busy                  : high while a request is in RUN or DONE
// Optional build macro ASCON_PERM_ABORT_EN adds an abort input that drops an
// in-flight request (RUN or DONE) and clears the state register.
module ascon_perm_ctrl
  import ascon_perm_pkg::*;
#(
  parameter int PB_ROUNDS = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [STATE_W-1:0] start_state,
  input  logic               start_pb,
  input  logic               start_fast,
`ifdef ASCON_PERM_ABORT_EN
  input  logic               abort,
`endif
  output logic [STATE_W-1:0] chain_x_in,
  output logic [2:0]         chain_loop_num,
  output logic               chain_const_sel,
  output logic [5:0]         chain_enable,
  output logic               chain_compact_fast,
  input  logic [STATE_W-1:0] chain_x_out_6,
  input  logic [STATE_W-1:0] chain_x_out_2,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [STATE_W-1:0] res_state,
  output logic               busy
);

  if (PB_ROUNDS != 6 && PB_ROUNDS != 8) begin : g_bad_pb_rounds
    $error("ascon_perm_ctrl: PB_ROUNDS must be 6 or 8");
  end

  perm_state_t        fsm;
  logic [STATE_W-1:0] st;
  logic [2:0]         cnt;
  logic               pb_q;
  logic               fast_q;
  logic               start_ready_q;
  logic               res_valid_q;
  logic               busy_q;

  logic [2:0]         plan_n;
  logic               plan_last;
  logic               plan_tap6;

  ascon_perm_plan #(.PB_ROUNDS(PB_ROUNDS)) u_plan (
    .pb      (pb_q),
    .fast    (fast_q),
    .counter (cnt),
    .n       (plan_n),
    .is_last (plan_last),
    .tap_sel (plan_tap6)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm           <= IDLE;
      st            <= '0;
      cnt           <= '0;
      pb_q          <= 1'b0;
      fast_q        <= 1'b0;
      start_ready_q <= 1'b0;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end
`ifdef ASCON_PERM_ABORT_EN
    else if (abort && fsm != IDLE) begin
      // Abort wins over a same-cycle result handshake; the result is dropped.
      fsm           <= IDLE;
      st            <= '0;
      cnt           <= '0;
      start_ready_q <= 1'b1;
      res_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end
`endif
    else begin
      case (fsm)
        IDLE: begin
          start_ready_q <= 1'b1;
          // Gating on the registered ready keeps the first post-reset cycle closed.
          if (start_valid && start_ready_q) begin
            st            <= start_state;
            pb_q          <= start_pb;
            fast_q        <= start_fast;
            cnt           <= '0;
            fsm           <= RUN;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
          end
        end
        RUN: begin
          st  <= plan_tap6 ? chain_x_out_6 : chain_x_out_2;
          cnt <= cnt + 3'd1;
          if (plan_last) begin
            fsm         <= DONE;
            res_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            fsm           <= IDLE;
            res_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            start_ready_q <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && fsm == RUN) begin
      assert (cnt < plan_n);
    end
  end

  assign start_ready        = start_ready_q;
  assign res_valid          = res_valid_q;
  assign busy               = busy_q;
  assign chain_x_in         = st;
  assign res_state          = st;
  assign chain_const_sel    = pb_q;
  assign chain_compact_fast = fast_q;
  assign chain_loop_num     = (fsm == RUN) ? cnt : 3'd0;
  assign chain_enable       = (fsm == RUN) ? (plan_tap6 ? EN_FULL : EN_TWO) : 6'd0;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Bench for ascon_perm_ctrl: two instances (PB_ROUNDS = 6 and 8) driven by a
// behavioural chain where x_out_6 = x_in + 6 and x_out_2 = x_in + 2, so a
// request of R rounds must return start_state + R.
module tb_ascon_perm_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n       [2];
  logic         start_valid [2];
  logic         start_ready [2];
  logic [319:0] start_state [2];
  logic         start_pb    [2];
  logic         start_fast  [2];
  logic [319:0] x_in        [2];
  logic [319:0] x6          [2];
  logic [319:0] x2          [2];
  logic [2:0]   loop_num    [2];
  logic         const_sel   [2];
  logic [5:0]   en          [2];
  logic         cfast       [2];
  logic         res_valid   [2];
  logic         res_ready   [2];
  logic [319:0] res_state   [2];
  logic         busy        [2];
`ifdef ASCON_PERM_ABORT_EN
  logic         abort       [2];
`endif

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign x6[g] = x_in[g] + 320'd6;
    assign x2[g] = x_in[g] + 320'd2;
    ascon_perm_ctrl #(.PB_ROUNDS(g == 0 ? 6 : 8)) u_dut (
      .clk                (clk),
      .rst_n              (rst_n[g]),
      .start_valid        (start_valid[g]),
      .start_ready        (start_ready[g]),
      .start_state        (start_state[g]),
      .start_pb           (start_pb[g]),
      .start_fast         (start_fast[g]),
`ifdef ASCON_PERM_ABORT_EN
      .abort              (abort[g]),
`endif
      .chain_x_in         (x_in[g]),
      .chain_loop_num     (loop_num[g]),
      .chain_const_sel    (const_sel[g]),
      .chain_enable       (en[g]),
      .chain_compact_fast (cfast[g]),
      .chain_x_out_6      (x6[g]),
      .chain_x_out_2      (x2[g]),
      .res_valid          (res_valid[g]),
      .res_ready          (res_ready[g]),
      .res_state          (res_state[g]),
      .busy               (busy[g])
    );
  end

  int checks = 0;
  int errors = 0;
  logic [319:0] last_res [2];

  task automatic chk(input string tag, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [319:0] rnd320();
    logic [319:0] r;
    for (int i = 0; i < 10; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // All outputs of unit u at their reset values.
  task automatic chk_zero(input int u, input string tag);
    chk({tag, "_start_ready"}, 320'(start_ready[u]), 320'd0);
    chk({tag, "_res_valid"},   320'(res_valid[u]),   320'd0);
    chk({tag, "_busy"},        320'(busy[u]),        320'd0);
    chk({tag, "_x_in"},        x_in[u],              320'd0);
    chk({tag, "_res_state"},   res_state[u],         320'd0);
    chk({tag, "_loop_num"},    320'(loop_num[u]),    320'd0);
    chk({tag, "_enable"},      320'(en[u]),          320'd0);
    chk({tag, "_const_sel"},   320'(const_sel[u]),   320'd0);
    chk({tag, "_cfast"},       320'(cfast[u]),       320'd0);
  endtask

  // Called at a negedge while unit u is IDLE: presents a request.
  task automatic issue(input int u, input logic [319:0] s, input bit pb, input bit fast);
    chk("idle_start_ready", 320'(start_ready[u]), 320'd1);
    chk("idle_busy", 320'(busy[u]), 320'd0);
    start_valid[u] = 1'b1;
    start_state[u] = s;
    start_pb[u]    = pb;
    start_fast[u]  = fast;
  endtask

  // Follows an accepted request through RUN and DONE. If nxt is set, the next
  // request (s2) is held on the start port through the result handshake.
  task automatic complete(input int u, input logic [319:0] s, input bit pb, input bit fast,
                          input int hold, input bit nxt,
                          input logic [319:0] s2, input bit pb2, input bit fast2);
    logic [5:0]   exp_en [$];
    int           rounds;
    int           rem;
    logic [319:0] acc;
    logic [319:0] want;
    rounds = pb ? ((u == 0) ? 6 : 8) : 12;
    rem = rounds;
    while (rem > 0) begin
      if (fast && rem >= 6) begin
        exp_en.push_back(6'h3F);
        rem -= 6;
      end else begin
        exp_en.push_back(6'h30);
        rem -= 2;
      end
    end
    acc  = s;
    want = s + 320'(rounds);
    @(negedge clk);
    // Start inputs wiggle while busy; none of it may be taken.
    start_valid[u] = 1'b1;
    start_state[u] = rnd320();
    start_pb[u]    = 1'($urandom);
    start_fast[u]  = 1'($urandom);
    for (int i = 0; i < exp_en.size(); i++) begin
      chk("run_loop_num",    320'(loop_num[u]),    320'(i));
      chk("run_enable",      320'(en[u]),          320'(exp_en[i]));
      chk("run_const_sel",   320'(const_sel[u]),   320'(pb));
      chk("run_cfast",       320'(cfast[u]),       320'(fast));
      chk("run_x_in",        x_in[u],              acc);
      chk("run_res_valid",   320'(res_valid[u]),   320'd0);
      chk("run_start_ready", 320'(start_ready[u]), 320'd0);
      chk("run_busy",        320'(busy[u]),        320'd1);
      acc = acc + ((exp_en[i] == 6'h3F) ? 320'd6 : 320'd2);
      @(negedge clk);
    end
    chk("done_res_valid",   320'(res_valid[u]),   320'd1);
    chk("done_res_state",   res_state[u],         want);
    chk("done_enable",      320'(en[u]),          320'd0);
    chk("done_loop_num",    320'(loop_num[u]),    320'd0);
    chk("done_busy",        320'(busy[u]),        320'd1);
    chk("done_start_ready", 320'(start_ready[u]), 320'd0);
    for (int h = 0; h < hold; h++) begin
      start_valid[u] = 1'b1;
      start_state[u] = rnd320();
      @(negedge clk);
      chk("hold_res_valid",   320'(res_valid[u]),   320'd1);
      chk("hold_res_state",   res_state[u],         want);
      chk("hold_start_ready", 320'(start_ready[u]), 320'd0);
    end
    res_ready[u]   = 1'b1;
    start_valid[u] = nxt;
    start_state[u] = s2;
    start_pb[u]    = pb2;
    start_fast[u]  = fast2;
    @(negedge clk);
    res_ready[u] = 1'b0;
    chk("post_res_valid",   320'(res_valid[u]),   320'd0);
    chk("post_busy",        320'(busy[u]),        320'd0);
    chk("post_start_ready", 320'(start_ready[u]), 320'd1);
    chk("post_res_state",   res_state[u],         want);
    last_res[u] = want;
  endtask

  initial begin
    bit           pend;
    bit           nx;
    int           pu;
    logic [319:0] ps;
    logic [319:0] s2;
    bit           ppb;
    bit           pf;
    bit           pb2;
    bit           f2;

    for (int u = 0; u < 2; u++) begin
      rst_n[u]       = 1'b0;
      start_valid[u] = 1'b0;
      start_state[u] = '0;
      start_pb[u]    = 1'b0;
      start_fast[u]  = 1'b0;
      res_ready[u]   = 1'b0;
      last_res[u]    = '0;
`ifdef ASCON_PERM_ABORT_EN
      abort[u]       = 1'b0;
`endif
    end
    repeat (3) @(negedge clk);
    chk_zero(0, "rst0");
    chk_zero(1, "rst1");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Fast p^a from 0: two full passes -> 12.
    issue(0, 320'd0, 1'b0, 1'b1);
    complete(0, 320'd0, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0);
    chk("fast_pa_result", last_res[0], 320'd12);

    // Compact p^b, 6 rounds, from 100 -> 106.
    issue(0, 320'd100, 1'b1, 1'b0);
    complete(0, 320'd100, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);
    chk("cmp_pb6_result", last_res[0], 320'd106);

    // Fast p^b, 8 rounds, from 5: enables 3F then 30 -> 13.
    issue(1, 320'd5, 1'b1, 1'b1);
    complete(1, 320'd5, 1'b1, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0);
    chk("fast_pb8_result", last_res[1], 320'd13);

    // Back-pressure for 10 cycles with start_valid high, then back-to-back accept.
    ps = rnd320();
    s2 = rnd320();
    issue(0, ps, 1'b0, 1'b1);
    complete(0, ps, 1'b0, 1'b1, 10, 1'b1, s2, 1'b1, 1'b0);
    complete(0, s2, 1'b1, 1'b0, 0, 1'b0, '0, 1'b0, 1'b0);

    // Reset in the middle of a compact p^a run.
    issue(1, 320'd77, 1'b0, 1'b0);
    @(negedge clk);
    start_valid[1] = 1'b0;
    repeat (3) @(negedge clk);
    chk("cut_loop_num", 320'(loop_num[1]), 320'd3);
    rst_n[1] = 1'b0;
    @(negedge clk);
    chk_zero(1, "midrst");
    rst_n[1] = 1'b1;
    @(negedge clk);
    chk("midrst_ready_back", 320'(start_ready[1]), 320'd1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_res", 320'(res_valid[1]), 320'd0);
    end

`ifdef ASCON_PERM_ABORT_EN
    // Abort in IDLE is ignored: state register keeps the last result.
    issue(0, 320'd40, 1'b0, 1'b1);
    complete(0, 320'd40, 1'b0, 1'b1, 0, 1'b0, '0, 1'b0, 1'b0);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_idle_ready", 320'(start_ready[0]), 320'd1);
    chk("abort_idle_state", x_in[0], 320'd52);

    // Abort in the second RUN cycle of compact p^a.
    issue(0, 320'd900, 1'b0, 1'b0);
    @(negedge clk);
    start_valid[0] = 1'b0;
    @(negedge clk);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    chk("abort_run_ready", 320'(start_ready[0]), 320'd1);
    chk("abort_run_busy",  320'(busy[0]),        320'd0);
    chk("abort_run_state", x_in[0],              320'd0);
    chk("abort_run_en",    320'(en[0]),          320'd0);
    for (int i = 0; i < 8; i++) begin
      chk("abort_run_no_res", 320'(res_valid[0]), 320'd0);
      @(negedge clk);
    end

    // Abort beats a same-cycle res_ready in DONE: state cleared, not retained.
    issue(1, 320'd31, 1'b0, 1'b1);
    @(negedge clk);
    start_valid[1] = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_done_valid", 320'(res_valid[1]), 320'd1);
    abort[1]     = 1'b1;
    res_ready[1] = 1'b1;
    @(negedge clk);
    abort[1]     = 1'b0;
    res_ready[1] = 1'b0;
    chk("abort_done_res_valid", 320'(res_valid[1]),   320'd0);
    chk("abort_done_state",     x_in[1],              320'd0);
    chk("abort_done_ready",     320'(start_ready[1]), 320'd1);
`endif

    // Randomised requests, occasionally back-to-back behind back-pressure.
    pend = 1'b0;
    pu   = 0;
    ppb  = 1'b0;
    pf   = 1'b0;
    for (int n = 0; n < 24; n++) begin
      if (!pend) begin
        pu  = $urandom_range(0, 1);
        ps  = rnd320();
        ppb = 1'($urandom);
        pf  = 1'($urandom);
        issue(pu, ps, ppb, pf);
      end
      nx  = (n < 23) && ($urandom_range(0, 3) == 0);
      s2  = rnd320();
      pb2 = 1'($urandom);
      f2  = 1'($urandom);
      complete(pu, ps, ppb, pf, $urandom_range(0, 3), nx, s2, pb2, f2);
      pend = nx;
      if (nx) begin
        ps  = s2;
        ppb = pb2;
        pf  = f2;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
